rv32_lsu: RTL and testbench
===========================

Name: rv32_lsu

Overview:
Load/store unit between the RV32 core's memory stage and the data memory.
- Takes a core access request (address, size, write data), generates a word-aligned memory transaction with byte enables and lane-shifted write data.
- Waits for the memory acknowledge and returns load data sign- or zero-extended.
- Stalls the core pipeline while the access is outstanding.
- The existing core-side debug taps (addr/we/req/size/wdata/rdata/stall_req) connect to this block's core-side ports.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waiting for mem_ack before a bus error; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- core_req  in  1  access request, held stable by core while core_stall_req=1
- core_we  in  1  1=store, 0=load
- core_size  in  3  access size/extension code, LDST_* encoding
- core_addr  in  ADDR_W  byte address
- core_wdata  in  32  store data, right-justified
- core_rdata  out  32  extended load data, valid while state=DONE
- core_stall_req  out  1  core must hold pipeline
- core_err  out  1  one-cycle pulse: bus timeout (or misalignment, see feature)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0]=0
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  memory read word, valid with mem_ack
- mem_ack  in  1  transaction complete

Behaviour:
- Reset: state IDLE; core_rdata=0, core_err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0. core_stall_req follows the combinational rule below (0 when core_req=0).
- Size codes: B=3'b000, H=3'b001, W=3'b010, BU=3'b100, HU=3'b101. Any other code is treated as W.
- FSM states: IDLE, BUSY, DONE.
- IDLE with core_req=1:
  - core_stall_req=1 combinationally.
  - Register we, size, addr[1:0], mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Register mem_be: B=0001<<a, H=0011<<a, W=1111 (a=addr[1:0]).
  - Register mem_wdata=core_wdata<<(8*a).
  - Next state BUSY.
- BUSY:
  - mem_req=1 and all mem_* outputs held constant until mem_ack.
  - core_stall_req=1.
  - Counter increments each cycle.
  - On mem_ack: latch core_rdata (loads only; stores leave it unchanged), clear mem_req next cycle, go to DONE.
- Load extension:
  - Select byte addr[1:0] or half addr[1] of mem_rdata.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Timeout: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without ack:
  - pulse core_err for 1 cycle;
  - core_rdata=32'hDEAD_BEEF;
  - deassert mem_req;
  - go to DONE.
- DONE:
  - core_stall_req=0 and core_rdata valid; core advances on this edge.
  - core_req is ignored; next state IDLE.
- Minimum latency, ack in first BUSY cycle: 3 cycles, IDLE→BUSY→DONE. Stall high for 2 cycles.
- Boundary conditions:
  - mem_ack in IDLE/DONE is ignored.
  - mem_ack in the same cycle the timeout fires: ack wins, no error.
  - rst mid-BUSY: immediate return to IDLE with mem_req=0; no ack expected after reset.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]≠0, detected in IDLE:
  - no mem_req;
  - core_err pulses in the following cycle;
  - go directly to DONE with core_rdata=0.
  - Latency 2 cycles.
- Undefined: low address bits are truncated to natural alignment (H: a[0]=0, W: a=0) and the access proceeds normally.

Decomposition:
- Package lsu_pkg:
  - size enum/localparams matching LDST_*;
  - FSM state enum;
  - TIMEOUT_RDATA constant;
  - functions be_gen(size,a) and wdata_align(data,a).
- One sub-module, lsu_load_ext: combinational lane select plus sign/zero extension (mem_rdata, size, a → 32-bit result).

Test Plan:
1. Store B 0xAA at addr 0x00, ack after 1 cycle → mem_addr=0x00, mem_be=0001, mem_wdata[7:0]=0xAA; stall high 2 cycles.
2. Store B 0xCC at 0x01 → mem_be=0010, mem_wdata=0x0000CC00. Store H 0xBBBB at 0x02 → mem_be=1100, mem_wdata=0xBBBB0000.
3. Store W 0x1111FAFB at 0x04 → mem_addr=0x04, mem_be=1111. Then load B at 0x05 with mem_rdata=0x1111FAFB → core_rdata=0xFFFFFFFA.
4. Load HU at 0x00 with mem_rdata=0xBBBBCCAA → core_rdata=0x0000CCAA. Load H at 0x00 → 0xFFFFCCAA.
5. Never ack, TIMEOUT_CYCLES=4 → core_err pulse after 4 BUSY cycles, core_rdata=0xDEADBEEF, mem_req drops.
6. With LSU_MISALIGN_TRAP_EN, load W at 0x02 → no mem_req, core_err pulse, stall 1 cycle. Separately, assert rst mid-BUSY → mem_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32 load/store unit.
// Covers size codes, FSM states, and byte-lane helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LDST_B  = 3'b000,
        LDST_H  = 3'b001,
        LDST_W  = 3'b010,
        LDST_BU = 3'b100,
        LDST_HU = 3'b101
    } ldst_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Unknown encodings fall back to a full-word access.
    function automatic ldst_size_e size_decode(input logic [2:0] code);
        case (code)
            3'b000:  return LDST_B;
            3'b001:  return LDST_H;
            3'b100:  return LDST_BU;
            3'b101:  return LDST_HU;
            default: return LDST_W;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input ldst_size_e size, input logic [1:0] a);
        case (size)
            LDST_B, LDST_BU: return 4'b0001 << a;
            LDST_H, LDST_HU: return 4'b0011 << a;
            default:         return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_align(input logic [31:0] data, input logic [1:0] a);
        return data << {a, 3'b000};
    endfunction

    function automatic logic is_misaligned(input ldst_size_e size, input logic [1:0] a);
        case (size)
            LDST_B, LDST_BU: return 1'b0;
            LDST_H, LDST_HU: return a[0];
            default:         return (a != 2'b00);
        endcase
    endfunction

    function automatic logic [1:0] natural_align(input ldst_size_e size, input logic [1:0] a);
        case (size)
            LDST_B, LDST_BU: return a;
            LDST_H, LDST_HU: return {a[1], 1'b0};
            default:         return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface rv32_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Load-data lane select with sign/zero extension.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  ldst_size_e  size,
    input  logic [1:0]  a,
    output logic [31:0] result
);
    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, then extend according to the access size.
    always_comb begin
        shifted_s = rdata >> {a, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LDST_B:  result = {{24{byte_s[7]}}, byte_s};
            LDST_BU: result = {24'd0, byte_s};
            LDST_H:  result = {{16{half_s[15]}}, half_s};
            LDST_HU: result = {16'd0, half_s};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/rv32_lsu.sv
// RV32 load/store unit: core request -> aligned memory transaction -> extended load data.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module rv32_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_size,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall_req,
    output logic              core_err,
    rv32_lsu_if.master        mem
);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    lsu_state_e        state_r, state_s;
    logic              we_r;
    ldst_size_e        size_r;
    logic [1:0]        a_r;
    logic [15:0]       cnt_r;
    logic              mem_req_r, mem_we_r;
    logic [3:0]        be_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r, rdata_r, load_s;
    logic              err_r;
    ldst_size_e        req_size_s;
    logic [1:0]        req_a_s;
    logic              misalign_s, timeout_s;

    // Decode the incoming request: size, effective lane offset, alignment fault.
    always_comb begin
        req_size_s = size_decode(core_size);
        misalign_s = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        req_a_s    = core_addr[1:0];
        misalign_s = is_misaligned(req_size_s, core_addr[1:0]);
`else
        req_a_s    = natural_align(req_size_s, core_addr[1:0]);
`endif
        timeout_s  = (TIMEOUT_LIM != 32'd0) && (({16'd0, cnt_r} + 32'd1) == TIMEOUT_LIM);
    end

    // Next-state logic; stall is combinational so the core freezes in the request cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (core_req) state_s = misalign_s ? ST_DONE : ST_BUSY;
                else          state_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (mem.mem_ack || timeout_s) state_s = ST_DONE;
                else                          state_s = ST_BUSY;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        core_stall_req = ((state_r == ST_IDLE) && core_req) || (state_r == ST_BUSY);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Request capture, bus hold, response latch; an ack beats a coincident timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r      <= 1'b0;
            size_r    <= LDST_W;
            a_r       <= 2'b00;
            cnt_r     <= 16'd0;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            be_r      <= 4'b0000;
            addr_r    <= '0;
            wdata_r   <= 32'd0;
            rdata_r   <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (core_req) begin
                        we_r   <= core_we;
                        size_r <= req_size_s;
                        a_r    <= req_a_s;
                        cnt_r  <= 16'd0;
                        if (misalign_s) begin
                            err_r   <= 1'b1;
                            rdata_r <= 32'd0;
                        end else begin
                            mem_req_r <= 1'b1;
                            mem_we_r  <= core_we;
                            be_r      <= be_gen(req_size_s, req_a_s);
                            addr_r    <= {core_addr[ADDR_W-1:2], 2'b00};
                            wdata_r   <= wdata_align(core_wdata, req_a_s);
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem.mem_ack) begin
                        mem_req_r <= 1'b0;
                        if (!we_r) rdata_r <= load_s;
                    end else if (timeout_s) begin
                        mem_req_r <= 1'b0;
                        err_r     <= 1'b1;
                        rdata_r   <= TIMEOUT_RDATA;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    lsu_load_ext u_load_ext (
        .rdata  (mem.mem_rdata),
        .size   (size_r),
        .a      (a_r),
        .result (load_s)
    );

    assign core_rdata    = rdata_r;
    assign core_err      = err_r;
    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_be    = be_r;
    assign mem.mem_addr  = addr_r;
    assign mem.mem_wdata = wdata_r;
endmodule

// File: tb/tb_rv32_lsu.sv
// Directed bench for rv32_lsu with TIMEOUT_CYCLES=4; honours LSU_MISALIGN_TRAP_EN.
module tb_rv32_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_stall_req, core_err;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wdata, core_rdata;

    int checks = 0;
    int errors = 0;

    logic        cap_seen, cap_we, res_err, res_req;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata, res_rdata;
    int          stall_cnt, busy_cnt;

    always #5 clk = ~clk;

    rv32_lsu_if #(.ADDR_W(32)) bus ();

    rv32_lsu #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_size      (core_size),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_rdata     (core_rdata),
        .core_stall_req (core_stall_req),
        .core_err       (core_err),
        .mem            (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One core access from IDLE; ack_wait<0 means memory never acks.
    task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_wait, input logic [31:0] rword);
        logic done;
        done = 1'b0;
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wdata = wdata;
        bus.mem_rdata = rword;
        stall_cnt = 0; busy_cnt = 0; cap_seen = 1'b0; cap_we = 1'b0;
        cap_be = 4'd0; cap_addr = 32'd0; cap_wdata = 32'd0;
        res_rdata = 32'd0; res_err = 1'b0; res_req = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.mem_ack = 1'b0;
            #1;
            if (core_stall_req) begin
                stall_cnt++;
                if (bus.mem_req) begin
                    if (!cap_seen) begin
                        cap_seen = 1'b1; cap_we = bus.mem_we; cap_be = bus.mem_be;
                        cap_addr = bus.mem_addr; cap_wdata = bus.mem_wdata;
                    end
                    busy_cnt++;
                    if (ack_wait >= 0 && busy_cnt > ack_wait) bus.mem_ack = 1'b1;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
                res_rdata = core_rdata; res_err = core_err; res_req = bus.mem_req;
            end
        end
        check_val("access_done", {31'd0, done}, 32'd1);
        core_req = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        #1;
        check_val("err_one_cycle", {31'd0, core_err}, 32'd0);
        check_val("back_idle", {31'd0, core_stall_req}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = 3'b010;
        core_addr = 32'd0; core_wdata = 32'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_rdata", core_rdata, 32'd0);
        check_val("rst_err", {31'd0, core_err}, 32'd0);
        check_val("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check_val("rst_be", {28'd0, bus.mem_be}, 32'd0);
        check_val("rst_addr", bus.mem_addr, 32'd0);
        check_val("rst_wdata", bus.mem_wdata, 32'd0);
        check_val("rst_stall", {31'd0, core_stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle
        bus.mem_ack = 1'b1;
        @(negedge clk);
        #1;
        check_val("idle_ack_req", {31'd0, bus.mem_req}, 32'd0);
        check_val("idle_ack_stall", {31'd0, core_stall_req}, 32'd0);
        bus.mem_ack = 1'b0;
        @(negedge clk);

        run_access(1'b1, 3'b000, 32'h0000_0000, 32'h0000_00AA, 0, 32'd0);
        check_val("sb0_addr", cap_addr, 32'h0000_0000);
        check_val("sb0_be", {28'd0, cap_be}, 32'h1);
        check_val("sb0_wdata", cap_wdata, 32'h0000_00AA);
        check_val("sb0_we", {31'd0, cap_we}, 32'd1);
        check_val("sb0_stall", stall_cnt, 32'd2);
        check_val("sb0_reqdrop", {31'd0, res_req}, 32'd0);

        run_access(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00CC, 0, 32'd0);
        check_val("sb1_be", {28'd0, cap_be}, 32'h2);
        check_val("sb1_wdata", cap_wdata, 32'h0000_CC00);

        run_access(1'b1, 3'b001, 32'h0000_0002, 32'h0000_BBBB, 0, 32'd0);
        check_val("sh2_be", {28'd0, cap_be}, 32'hC);
        check_val("sh2_wdata", cap_wdata, 32'hBBBB_0000);

        run_access(1'b1, 3'b010, 32'h0000_0004, 32'h1111_FAFB, 0, 32'd0);
        check_val("sw4_addr", cap_addr, 32'h0000_0004);
        check_val("sw4_be", {28'd0, cap_be}, 32'hF);
        check_val("sw4_wdata", cap_wdata, 32'h1111_FAFB);

        run_access(1'b0, 3'b000, 32'h0000_0005, 32'd0, 0, 32'h1111_FAFB);
        check_val("lb5_be", {28'd0, cap_be}, 32'h2);
        check_val("lb5_we", {31'd0, cap_we}, 32'd0);
        check_val("lb5_addr", cap_addr, 32'h0000_0004);
        check_val("lb5_rdata", res_rdata, 32'hFFFF_FFFA);

        run_access(1'b0, 3'b101, 32'h0000_0000, 32'd0, 1, 32'hBBBB_CCAA);
        check_val("lhu0_rdata", res_rdata, 32'h0000_CCAA);
        check_val("lhu0_stall", stall_cnt, 32'd3);

        run_access(1'b0, 3'b001, 32'h0000_0000, 32'd0, 0, 32'hBBBB_CCAA);
        check_val("lh0_rdata", res_rdata, 32'hFFFF_CCAA);

        // A store must not disturb the previous load result
        run_access(1'b1, 3'b111, 32'h0000_0008, 32'h5555_6666, 0, 32'h0123_4567);
        check_val("sw_odd_code_be", {28'd0, cap_be}, 32'hF);
        check_val("st_keeps_rdata", res_rdata, 32'hFFFF_CCAA);

        run_access(1'b0, 3'b100, 32'h0000_0003, 32'd0, 0, 32'h8000_0000);
        check_val("lbu3_rdata", res_rdata, 32'h0000_0080);
        run_access(1'b0, 3'b001, 32'h0000_0002, 32'd0, 0, 32'h7FFF_0000);
        check_val("lh2_rdata", res_rdata, 32'h0000_7FFF);

        run_access(1'b0, 3'b010, 32'h0000_0010, 32'd0, -1, 32'd0);
        check_val("to_busy", busy_cnt, 32'd4);
        check_val("to_stall", stall_cnt, 32'd5);
        check_val("to_err", {31'd0, res_err}, 32'd1);
        check_val("to_rdata", res_rdata, 32'hDEAD_BEEF);
        check_val("to_reqdrop", {31'd0, res_req}, 32'd0);

        // Ack on the cycle the timeout would fire
        run_access(1'b0, 3'b010, 32'h0000_0010, 32'd0, 3, 32'h1234_5678);
        check_val("ackto_busy", busy_cnt, 32'd4);
        check_val("ackto_err", {31'd0, res_err}, 32'd0);
        check_val("ackto_rdata", res_rdata, 32'h1234_5678);

`ifdef LSU_MISALIGN_TRAP_EN
        run_access(1'b0, 3'b010, 32'h0000_0002, 32'd0, 0, 32'hCAFE_F00D);
        check_val("mis_w_noreq", {31'd0, cap_seen}, 32'd0);
        check_val("mis_w_stall", stall_cnt, 32'd1);
        check_val("mis_w_err", {31'd0, res_err}, 32'd1);
        check_val("mis_w_rdata", res_rdata, 32'd0);
        run_access(1'b0, 3'b101, 32'h0000_0003, 32'd0, 0, 32'hABCD_1234);
        check_val("mis_h_noreq", {31'd0, cap_seen}, 32'd0);
        check_val("mis_h_err", {31'd0, res_err}, 32'd1);
`else
        run_access(1'b0, 3'b010, 32'h0000_0002, 32'd0, 0, 32'hCAFE_F00D);
        check_val("trunc_w_addr", cap_addr, 32'h0000_0000);
        check_val("trunc_w_be", {28'd0, cap_be}, 32'hF);
        check_val("trunc_w_rdata", res_rdata, 32'hCAFE_F00D);
        check_val("trunc_w_err", {31'd0, res_err}, 32'd0);
        run_access(1'b0, 3'b001, 32'h0000_0003, 32'd0, 0, 32'hABCD_1234);
        check_val("trunc_h_be", {28'd0, cap_be}, 32'hC);
        check_val("trunc_h_rdata", res_rdata, 32'hFFFF_ABCD);
`endif

        // Reset while a transaction is outstanding
        core_req = 1'b1; core_we = 1'b0; core_size = 3'b010; core_addr = 32'h0000_0020;
        @(negedge clk);
        #1;
        check_val("midrst_busy_req", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("midrst_req", {31'd0, bus.mem_req}, 32'd0);
        check_val("midrst_err", {31'd0, core_err}, 32'd0);
        core_req = 1'b0;
        #1;
        check_val("midrst_idle", {31'd0, core_stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_access(1'b0, 3'b000, 32'h0000_0006, 32'd0, 0, 32'h0042_0000);
        check_val("postrst_rdata", res_rdata, 32'h0000_0042);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
